prefetch_queue: RTL
===================

Name: prefetch_queue

Overview:
- Parametrised instruction-byte prefetch queue between the x8086 core's decode front end and the memory bus.
- Fetches aligned bus words from CS:IP while space allows, handles odd and unaligned IP, and presents up to PEEK bytes per cycle to the decoder.
- Replaces the core's single-byte, IP-driven fetch; flushes and re-targets on jumps.

Parameters:
- DEPTH, 6, queue capacity in bytes (4..16).
- BUS_BYTES, 2, bytes per bus word (1, 2 or 4).
- PEEK, 2, bytes presented at q_data and maximum consumed per cycle (1..DEPTH).
- ADDR_W, 20, physical address width.
- RESET_CS, 16'hFFFF, CS after reset.
- RESET_IP, 16'h0000, IP after reset.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- locked  in  1  PLL ready; when 0, no new requests are issued and no bytes are consumed.
- flush  in  1  discard the queue and restart fetch at flush_cs:flush_ip.
- flush_cs  in  16  new code segment.
- flush_ip  in  16  new instruction pointer.
- mem_req  out  1  bus request.
- mem_addr  out  ADDR_W  word-aligned physical address.
- mem_ready  in  1  data valid / transfer complete.
- mem_data  in  8*BUS_BYTES  read word; byte k occupies [8k+7:8k].
- q_data  out  8*PEEK  queue head; byte 0 occupies [7:0].
- q_count  out  $clog2(DEPTH+1)  valid bytes in the queue.
- q_consume  in  $clog2(PEEK+1)  bytes the decoder pops this cycle.
- q_ip  out  16  IP of q_data byte 0.

Behaviour:
- Reset values: mem_req=0, mem_addr=0, q_data=0, q_count=0, q_ip=RESET_IP, cs=RESET_CS, fetch_ip=RESET_IP, state=IDLE.
- Physical address: ({cs,4'h0}+fetch_ip) mod 2^ADDR_W, with the low log2(BUS_BYTES) bits cleared.
- Byte offset: off = fetch_ip mod BUS_BYTES. Bytes taken from a word: n = BUS_BYTES-off, i.e. lanes off..BUS_BYTES-1, enqueued in ascending lane order.
- FSM states: IDLE, REQ, DISCARD.
- IDLE -> REQ when locked=1, flush=0 and DEPTH-q_count >= n. mem_req and mem_addr are registered; mem_req rises on the next edge.
- REQ: mem_req=1 and mem_addr are held stable until mem_ready=1 is sampled.
  - On that edge: the n bytes are enqueued and fetch_ip += n (16-bit wrap; cs unchanged).
  - If space remains for the next word, stay in REQ with the new address (no bubble); otherwise go to IDLE with mem_req=0.
- Space is checked at issue only. Consumption only frees space, so overflow is impossible.
- Consume: effective pop = min(q_consume, q_count); q_count -= pop; q_ip += pop (16-bit wrap).
- Fill and consume in the same cycle: both are applied; new q_count = q_count - pop + n.
- q_data bytes at positions >= q_count read as 8'h00.
- Latency: bytes captured at edge N are visible on q_data/q_count after edge N.
- flush (priority over consume and fill):
  - q_count <= 0, q_ip <= flush_ip, fetch_ip <= flush_ip, cs <= flush_cs.
  - In REQ with mem_ready=0: go to DISCARD. The handshake is kept (mem_req and the old address held), the returned word is dropped, then go to IDLE.
  - In REQ with mem_ready=1 on the same edge: the word is dropped and the FSM goes to IDLE.
  - flush in DISCARD only updates the target.
- locked=0: consumption is ignored and no new request is issued. An outstanding request completes and its data is enqueued. flush is still honoured.
- Reset asserted mid-transfer: immediate return to reset values; the bus side tolerates the abandoned request.

Optional Feature:
- Macro: PFQ_BYPASS_EN.
- Defined:
  - In the cycle mem_ready=1 is sampled in REQ (not DISCARD, no flush), q_data and q_count combinationally include the incoming bytes.
  - q_consume may pop them in that same cycle, giving zero-cycle latency from an empty queue.
- Undefined: registered path only; one cycle from capture to visibility.

Decomposition:
- pfq_pkg:
  - state enum (IDLE, REQ, DISCARD);
  - function phys_addr(cs, ip, ADDR_W);
  - function lane_offset(ip, BUS_BYTES).
- One sub-module, pfq_byte_ring:
  - DEPTH-byte circular buffer with head/tail pointers modulo DEPTH;
  - write of 0..BUS_BYTES bytes and read of 0..PEEK bytes per cycle;
  - synchronous clear.

Test Plan:
- Reset release, locked=1: mem_req=1 on the second edge with mem_addr=20'hFFFF0 and q_ip=16'h0000.
- DEPTH=6, BUS_BYTES=2, mem_ready always 1, q_consume=0: exactly 3 transfers, then q_count=6 and mem_req=0. Pop 1 -> no request; pop 1 more -> request at IP+6.
- flush cs=16'h1000, ip=16'h0103: mem_addr=20'h10102, only lane 1 is enqueued, q_count=1, q_ip=16'h0103; next mem_addr=20'h10104.
- Flush while mem_ready is held low 3 cycles: DISCARD is entered, the returned word is not enqueued, q_count stays 0, next mem_addr is the flush target.
- cs=0, ip=16'hFFFE: word at 20'h0FFFE, then mem_addr=20'h00000. After popping 2 bytes, q_ip wraps to 16'h0000.
- q_count=2, q_consume=2 and mem_ready=1 on the same edge: q_count=2 holding the new bytes. With PFQ_BYPASS_EN and an empty queue, the popped bytes equal mem_data that same cycle.

Source files
------------

// File: rtl/pfq_pkg.sv
// Shared types and address helpers for the x8086 instruction prefetch queue.
package pfq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } pfq_state_e;

    // Linear address {cs,4'h0}+ip truncated to addr_w bits (addr_w <= 32).
    function automatic logic [31:0] phys_addr(input logic [15:0] cs,
                                              input logic [15:0] ip,
                                              input int          addr_w);
        logic [31:0] sum;
        logic [31:0] mask;
        sum  = {12'h000, cs, 4'h0} + {16'h0000, ip};
        mask = (addr_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << addr_w) - 32'd1);
        return sum & mask;
    endfunction

    function automatic int lane_offset(input logic [15:0] ip, input int bus_bytes);
        return int'(ip) % bus_bytes;
    endfunction

endpackage

// File: rtl/pfq_byte_ring.sv
// DEPTH-byte circular buffer with multi-byte write/read and synchronous clear.
// With PFQ_BYPASS_EN defined, bytes being written are also visible at the head view.
module pfq_byte_ring #(
    parameter int DEPTH     = 6,
    parameter int BUS_BYTES = 2,
    parameter int PEEK      = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             clr,
    input  logic [$clog2(BUS_BYTES+1)-1:0]   wr_cnt,
    input  logic [8*BUS_BYTES-1:0]           wr_data,
    input  logic [$clog2(PEEK+1)-1:0]        rd_cnt,
    output logic [8*PEEK-1:0]                peek_data,
    output logic [$clog2(DEPTH+1)-1:0]       count,
    output logic [$clog2(DEPTH+1)-1:0]       avail
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    // Step never exceeds DEPTH, so one conditional subtraction wraps it.
    function automatic logic [PW-1:0] wrap(input int base, input int step);
        int s;
        s = base + step;
        return PW'((s >= DEPTH) ? s - DEPTH : s);
    endfunction

    // Next pointer, count and storage contents.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clr) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            for (int k = 0; k < BUS_BYTES; k++) begin
                if (k < int'(wr_cnt)) begin
                    mem_d[wrap(int'(tail_q), k)] = wr_data[8*k +: 8];
                end else begin
                    mem_d[wrap(int'(tail_q), k)] = mem_q[wrap(int'(tail_q), k)];
                end
            end
            tail_d  = wrap(int'(tail_q), int'(wr_cnt));
            head_d  = wrap(int'(head_q), int'(rd_cnt));
            count_d = CW'(int'(count_q) + int'(wr_cnt) - int'(rd_cnt));
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= 8'h00;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

`ifdef PFQ_BYPASS_EN
    logic [8*BUS_BYTES-1:0] byp_word_s;

    // Head view: stored bytes first, then the bytes arriving this cycle.
    always_comb begin
        peek_data  = '0;
        byp_word_s = '0;
        for (int p = 0; p < PEEK; p++) begin
            if (p < int'(count_q)) begin
                peek_data[8*p +: 8] = mem_q[wrap(int'(head_q), p)];
            end else if ((p - int'(count_q)) < int'(wr_cnt)) begin
                byp_word_s          = wr_data >> (8 * (p - int'(count_q)));
                peek_data[8*p +: 8] = byp_word_s[7:0];
            end else begin
                peek_data[8*p +: 8] = 8'h00;
            end
        end
    end

    assign avail = count_q + CW'(wr_cnt);
`else
    // Head view of stored bytes; empty positions read as zero.
    always_comb begin
        peek_data = '0;
        for (int p = 0; p < PEEK; p++) begin
            if (p < int'(count_q)) begin
                peek_data[8*p +: 8] = mem_q[wrap(int'(head_q), p)];
            end else begin
                peek_data[8*p +: 8] = 8'h00;
            end
        end
    end

    assign avail = count_q;
`endif

    assign count = count_q;

endmodule

// File: rtl/prefetch_queue.sv
// x8086 instruction prefetch queue: fetches aligned bus words from CS:IP into a byte ring.
// Optional same-cycle bypass of returning bytes is enabled by defining PFQ_BYPASS_EN.
module prefetch_queue
    import pfq_pkg::*;
#(
    parameter int          DEPTH     = 6,
    parameter int          BUS_BYTES = 2,
    parameter int          PEEK      = 2,
    parameter int          ADDR_W    = 20,
    parameter logic [15:0] RESET_CS  = 16'hFFFF,
    parameter logic [15:0] RESET_IP  = 16'h0000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         locked,
    input  logic                         flush,
    input  logic [15:0]                  flush_cs,
    input  logic [15:0]                  flush_ip,
    output logic                         mem_req,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic                         mem_ready,
    input  logic [8*BUS_BYTES-1:0]       mem_data,
    output logic [8*PEEK-1:0]            q_data,
    output logic [$clog2(DEPTH+1)-1:0]   q_count,
    input  logic [$clog2(PEEK+1)-1:0]    q_consume,
    output logic [15:0]                  q_ip
);

    localparam int CW  = $clog2(DEPTH+1);
    localparam int WCW = $clog2(BUS_BYTES+1);
    localparam int PCW = $clog2(PEEK+1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BUS_BYTES - 1);

    pfq_state_e          state_q, state_d;
    logic [15:0]         cs_q, cs_d;
    logic [15:0]         fetch_ip_q, fetch_ip_d;
    logic [15:0]         q_ip_q, q_ip_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

    int                  off_s;
    int                  n_s;
    int                  pop_s;
    int                  cnt_after_s;
    logic                cap_s;
    logic [WCW-1:0]      wr_cnt_s;
    logic [8*BUS_BYTES-1:0] wr_data_s;
    logic [PCW-1:0]      rd_cnt_s;
    logic [CW-1:0]       ring_count_s;
    logic [CW-1:0]       ring_avail_s;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [15:0] cs, input logic [15:0] ip);
        return ADDR_W'(phys_addr(cs, ip, ADDR_W)) & ALIGN_MASK;
    endfunction

    // Capture of the returning word: lanes off..BUS_BYTES-1 shifted down to byte 0.
    always_comb begin
        off_s     = lane_offset(fetch_ip_q, BUS_BYTES);
        n_s       = BUS_BYTES - off_s;
        cap_s     = (state_q == ST_REQ) && mem_ready && !flush;
        wr_cnt_s  = cap_s ? WCW'(n_s) : '0;
        wr_data_s = mem_data >> (8 * off_s);
    end

    // Decoder pop, clamped to what is visible and gated by locked/flush.
    always_comb begin
        if (locked && !flush) begin
            pop_s = (int'(q_consume) < int'(ring_avail_s)) ? int'(q_consume) : int'(ring_avail_s);
        end else begin
            pop_s = 0;
        end
        rd_cnt_s    = PCW'(pop_s);
        cnt_after_s = int'(ring_count_s) + int'(wr_cnt_s) - pop_s;
    end

    // Fetch target and head IP; flush overrides everything.
    always_comb begin
        if (flush) begin
            cs_d       = flush_cs;
            fetch_ip_d = flush_ip;
            q_ip_d     = flush_ip;
        end else begin
            cs_d       = cs_q;
            fetch_ip_d = cap_s ? fetch_ip_q + 16'(n_s) : fetch_ip_q;
            q_ip_d     = q_ip_q + 16'(pop_s);
        end
    end

    // Bus FSM; mem_req/mem_addr are registered from the next state.
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (locked && !flush && ((DEPTH - int'(ring_count_s)) >= n_s)) begin
                    state_d    = ST_REQ;
                    mem_addr_d = word_addr(cs_q, fetch_ip_q);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (flush) begin
                    // A pending handshake must still complete; its data is dropped.
                    state_d = mem_ready ? ST_IDLE : ST_DISCARD;
                end else if (mem_ready) begin
                    if (locked && ((DEPTH - cnt_after_s) >= BUS_BYTES)) begin
                        state_d    = ST_REQ;
                        mem_addr_d = word_addr(cs_q, fetch_ip_d);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DISCARD: begin
                state_d = mem_ready ? ST_IDLE : ST_DISCARD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        mem_req_d = (state_d != ST_IDLE);
    end

    // Control and bus-output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cs_q       <= RESET_CS;
            fetch_ip_q <= RESET_IP;
            q_ip_q     <= RESET_IP;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cs_q       <= cs_d;
            fetch_ip_q <= fetch_ip_d;
            q_ip_q     <= q_ip_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    pfq_byte_ring #(
        .DEPTH     (DEPTH),
        .BUS_BYTES (BUS_BYTES),
        .PEEK      (PEEK)
    ) u_ring (
        .clock     (clock),
        .reset     (reset),
        .clr       (flush),
        .wr_cnt    (wr_cnt_s),
        .wr_data   (wr_data_s),
        .rd_cnt    (rd_cnt_s),
        .peek_data (q_data),
        .count     (ring_count_s),
        .avail     (ring_avail_s)
    );

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign q_count  = ring_avail_s;
    assign q_ip     = q_ip_q;

endmodule
